mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the processor's single-ported data memory between the CPU control FSM (data loads/stores) and a debug loader that writes program/data bytes while the board runs. It sits between both requesters and the synchronous memory's data port, serialises single-byte transactions with round-robin fairness, and returns read data after the memory's fixed read latency.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and requester port indices.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RWAIT = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; purely combinational, the last-grant history lives in the caller.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_vld,
  output logic gnt
);

  always_comb begin
    gnt_vld = req0 | req1;
    if (req0 && req1) begin
      gnt = (last_gnt == PORT_CPU) ? PORT_DBG : PORT_CPU;
    end else if (req1) begin
      gnt = PORT_DBG;
    end else begin
      gnt = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between the CPU and the debug loader, one byte per transaction,
// round-robin on ties; writes take two cycles, reads two plus the memory read latency.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              owner
);

  state_t            state;
  state_t            state_nxt;
  logic              last_gnt;
  logic              cmd_port;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              gnt_vld;
  logic              gnt;
  logic              grant;
  logic              wr_done;
  logic              rd_done;

  rr_arb2 u_rr_arb2 (
    .req0     (cpu_req),
    .req1     (dbg_req),
    .last_gnt (last_gnt),
    .gnt_vld  (gnt_vld),
    .gnt      (gnt)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          grant     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wr_done   = cmd_we;
        state_nxt = cmd_we ? ST_IDLE : ST_RWAIT;
      end
      ST_RWAIT: begin
        if (wait_cnt == 2'd1) begin
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode from state so an async reset drops them without waiting for an edge.
  assign mem_wren = (state == ST_ISSUE) &&  cmd_we;
  assign mem_rden = (state == ST_ISSUE) && !cmd_we;
  assign mem_addr = cmd_addr;
  assign mem_data = cmd_wdata;
  assign busy     = (state != ST_IDLE);
  assign owner    = cmd_port;
  assign cpu_ack  = (wr_done | rd_done) && (cmd_port == PORT_CPU);
  assign dbg_ack  = (wr_done | rd_done) && (cmd_port == PORT_DBG);

  // Read data arrives on mem_q in the ack cycle; forward it then, hold the captured copy afterwards.
  assign cpu_rdata = (rd_done && cmd_port == PORT_CPU) ? mem_q : cpu_rdata_q;
  assign dbg_rdata = (rd_done && cmd_port == PORT_DBG) ? mem_q : dbg_rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_gnt    <= PORT_DBG;
      cmd_port    <= PORT_CPU;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      wait_cnt    <= 2'd0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        cmd_port  <= gnt;
        last_gnt  <= gnt;
        cmd_we    <= (gnt == PORT_DBG) ? dbg_we    : cpu_we;
        cmd_addr  <= (gnt == PORT_DBG) ? dbg_addr  : cpu_addr;
        cmd_wdata <= (gnt == PORT_DBG) ? dbg_wdata : cpu_wdata;
      end
      if (state == ST_ISSUE && !cmd_we) begin
        wait_cnt <= 2'(READ_LAT);
      end else if (state == ST_RWAIT) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (rd_done && cmd_port == PORT_CPU) cpu_rdata_q <= mem_q;
      if (rd_done && cmd_port == PORT_DBG) dbg_rdata_q <= mem_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of the memory port arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  always #5 clock = ~clock;

  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_ack, dbg_ack, mem_wren, mem_rden, busy, owner;
  logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_data, mem_q;

  logic       c2_req, c2_we, d2_req, d2_we;
  logic [7:0] c2_addr, c2_wdata, d2_addr, d2_wdata;
  logic       c2_ack, d2_ack, m2_wren, m2_rden, busy2, owner2;
  logic [7:0] c2_rdata, d2_rdata, m2_addr, m2_data, m2_q;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_q(mem_q), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(2)) dut2 (
    .clock(clock), .reset(reset),
    .cpu_req(c2_req), .cpu_we(c2_we), .cpu_addr(c2_addr), .cpu_wdata(c2_wdata),
    .cpu_ack(c2_ack), .cpu_rdata(c2_rdata),
    .dbg_req(d2_req), .dbg_we(d2_we), .dbg_addr(d2_addr), .dbg_wdata(d2_wdata),
    .dbg_ack(d2_ack), .dbg_rdata(d2_rdata),
    .mem_addr(m2_addr), .mem_data(m2_data), .mem_wren(m2_wren), .mem_rden(m2_rden),
    .mem_q(m2_q), .busy(busy2), .owner(owner2)
  );

  // Synchronous memories: latency 1 for dut, latency 2 for dut2.
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] q1, q2a, q2b;
  always @(posedge clock) begin
    if (mem_rden) q1 <= mem1[mem_addr];
    if (mem_wren) mem1[mem_addr] = mem_data;
  end
  always @(posedge clock) begin
    if (m2_rden) q2a <= mem2[m2_addr];
    q2b <= q2a;
    if (m2_wren) mem2[m2_addr] = m2_data;
  end
  assign mem_q = q1;
  assign m2_q  = q2b;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end else begin
      dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transaction-level model state for the random phase.
  logic       pend [2];
  logic       p_we [2];
  logic [3:0] p_addr [2];
  logic [7:0] p_wd [2];
  int         age [2];
  int         foreign [2];
  logic [7:0] exp_rdata [2];
  logic [7:0] ref_mem [16];

  initial begin
    int n;
    logic got;
    logic [1:0] acks;
    logic [7:0] obs_rd;

    reset = 1'b1;
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    c2_req = 0; c2_we = 0; c2_addr = 0; c2_wdata = 0;
    d2_req = 0; d2_we = 0; d2_addr = 0; d2_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'hEE;
      mem2[i] = 8'hEE;
    end
    mem1[8'h20] = 8'h3C;
    mem2[8'h20] = 8'h3C;
    q1 = 0; q2a = 0; q2b = 0;

    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_rden", mem_rden, 0);
    chk("rst_owner", owner, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    reset = 1'b0;
    step();

    // CPU write 0x10 <= 0xA5
    drive(0, 1, 1, 8'h10, 8'hA5);
    step();
    chk("wr_wren", mem_wren, 1);
    chk("wr_rden", mem_rden, 0);
    chk("wr_addr", mem_addr, 8'h10);
    chk("wr_data", mem_data, 8'hA5);
    chk("wr_cpu_ack", cpu_ack, 1);
    chk("wr_dbg_ack", dbg_ack, 0);
    chk("wr_busy", busy, 1);
    drive(0, 0, 0, 8'h00, 8'h00);
    step();
    chk("wr_ack_gone", cpu_ack, 0);
    chk("wr_idle", busy, 0);
    chk("wr_mem", mem1[8'h10], 8'hA5);

    // CPU readback of 0x10, then read of 0x20
    drive(0, 1, 0, 8'h10, 8'h00);
    step();
    chk("rb_rden", mem_rden, 1);
    chk("rb_ack_early", cpu_ack, 0);
    step();
    chk("rb_ack", cpu_ack, 1);
    chk("rb_rdata", cpu_rdata, 8'hA5);
    chk("rb_rwait_rden", mem_rden, 0);
    drive(0, 1, 0, 8'h20, 8'h00);
    step();
    chk("rd_idle_ack", cpu_ack, 0);
    chk("rd_idle_busy", busy, 0);
    step();
    chk("rd_issue_ack", cpu_ack, 0);
    chk("rd_issue_addr", mem_addr, 8'h20);
    drive(0, 0, 0, 8'h00, 8'h00);
    step();
    chk("rd_ack", cpu_ack, 1);
    chk("rd_rdata", cpu_rdata, 8'h3C);
    chk("rd_dbg_ack", dbg_ack, 0);
    step();
    chk("rd_ack_once", cpu_ack, 0);
    chk("rd_hold", cpu_rdata, 8'h3C);
    step();
    chk("rd_stay_idle", busy, 0);

    // Both requesting from reset: CPU first, then strict alternation
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 1, 1, 8'h00, 8'h01);
    drive(1, 1, 1, 8'h01, 8'h02);
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      step();
      if (cpu_ack || dbg_ack) begin
        chk($sformatf("alt_grant%0d", n), {cpu_ack, dbg_ack}, (n % 2 == 0) ? 2'b10 : 2'b01);
        n++;
        if (n == 8) begin
          drive(0, 0, 0, 8'h00, 8'h00);
          drive(1, 0, 0, 8'h00, 8'h00);
        end
      end
    end
    chk("alt_count", n, 8);
    chk("alt_mem0", mem1[8'h00], 8'h01);
    chk("alt_mem1", mem1[8'h01], 8'h02);
    step(); step();
    chk("alt_idle", busy, 0);

    // Debug read of 0x30 while a CPU write is pending
    mem1[8'h30] = 8'h55;
    drive(1, 1, 0, 8'h30, 8'h00);
    step();
    drive(0, 1, 1, 8'h31, 8'h9E);
    chk("dr_owner", owner, 1);
    step();
    chk("dr_dbg_ack", dbg_ack, 1);
    chk("dr_dbg_rdata", dbg_rdata, 8'h55);
    chk("dr_cpu_ack", cpu_ack, 0);
    chk("dr_cpu_rdata", cpu_rdata, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    got = 1'b0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      step();
      if (cpu_ack) got = 1'b1;
    end
    chk("dr_cpu_done", got, 1);
    drive(0, 0, 0, 8'h00, 8'h00);
    step();
    chk("dr_mem", mem1[8'h31], 8'h9E);
    chk("dr_dbg_hold", dbg_rdata, 8'h55);
    chk("dr_cpu_rdata_hold", cpu_rdata, 8'h00);

    // Reset during ISSUE of a write aborts it before the write edge
    mem1[8'h40] = 8'h11;
    drive(0, 1, 1, 8'h40, 8'h77);
    step();
    chk("rs_wren_pre", mem_wren, 1);
    reset = 1'b1;
    #1;
    chk("rs_wren", mem_wren, 0);
    chk("rs_ack", cpu_ack, 0);
    chk("rs_busy", busy, 0);
    chk("rs_cpu_rdata", cpu_rdata, 0);
    chk("rs_dbg_rdata", dbg_rdata, 0);
    chk("rs_addr", mem_addr, 0);
    drive(0, 0, 0, 8'h00, 8'h00);
    @(posedge clock);
    #1;
    chk("rs_mem", mem1[8'h40], 8'h11);
    step();
    reset = 1'b0;
    step();

    // READ_LAT=2 instance: read of 0x20 with req dropped before RWAIT
    c2_req = 1; c2_we = 0; c2_addr = 8'h20;
    step();
    chk("l2_rden", m2_rden, 1);
    chk("l2_ack_issue", c2_ack, 0);
    c2_req = 0;
    step();
    chk("l2_ack_wait", c2_ack, 0);
    chk("l2_busy", busy2, 1);
    chk("l2_rden_wait", m2_rden, 0);
    step();
    chk("l2_ack", c2_ack, 1);
    chk("l2_rdata", c2_rdata, 8'h3C);
    chk("l2_dbg_ack", d2_ack, 0);
    step();
    chk("l2_ack_once", c2_ack, 0);
    chk("l2_hold", c2_rdata, 8'h3C);
    chk("l2_idle", busy2, 0);
    step();
    chk("l2_stay_idle", {busy2, m2_rden, m2_wren}, 3'b000);

    // Randomized traffic on both ports of the READ_LAT=1 instance
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      mem1[8'h80 + i] = ref_mem[i];
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0;
      age[p] = 0; foreign[p] = 0; exp_rdata[p] = 8'h00;
    end
    for (int cyc = 0; cyc < 640; cyc++) begin
      step();
      acks = {dbg_ack, cpu_ack};
      if (acks == 2'b11) chk("rnd_dual_ack", acks, 2'b01);
      for (int p = 0; p < 2; p++) begin
        if (acks[p]) begin
          obs_rd = (p == 0) ? cpu_rdata : dbg_rdata;
          chk("rnd_ack_pending", pend[p], 1);
          chk("rnd_owner", owner, p);
          chk("rnd_fair", foreign[p], (foreign[p] > 1) ? 1 : foreign[p]);
          chk("rnd_latency", (age[p] <= 8) ? 1 : 0, 1);
          if (pend[p] && !p_we[p]) exp_rdata[p] = ref_mem[p_addr[p]];
          if (pend[p] && p_we[p]) ref_mem[p_addr[p]] = p_wd[p];
          chk($sformatf("rnd_rdata_p%0d", p), obs_rd, exp_rdata[p]);
          chk($sformatf("rnd_other_hold_p%0d", 1 - p), (p == 0) ? dbg_rdata : cpu_rdata, exp_rdata[1 - p]);
          pend[p] = 0;
          if (pend[1 - p]) foreign[1 - p]++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          age[p]++;
          if (age[p] > 12) begin
            chk("rnd_timeout", pend[p], 0);
            pend[p] = 0;
            drive(p, 0, 0, 8'h00, 8'h00);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if (cyc < 600 && $urandom_range(0, 2) != 0) begin
            pend[p] = 1;
            p_we[p] = 1'($urandom_range(0, 1));
            p_addr[p] = 4'($urandom_range(0, 15));
            p_wd[p] = 8'($urandom);
            age[p] = 0;
            foreign[p] = 0;
            drive(p, 1, p_we[p], {4'h8, p_addr[p]}, p_wd[p]);
          end else begin
            drive(p, 0, 0, 8'h00, 8'h00);
          end
        end
      end
    end
    chk("rnd_drained", {pend[1], pend[0]}, 2'b00);
    chk("rnd_idle", busy, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rnd_mem%0d", i), mem1[8'h80 + i], ref_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
